flag_stack_reg: RTL and testbench
=================================

// Module: flag_stack_reg
// PURPOSE
//  Parametrised processor flag register (carry/zero/etc.) with per-bit masked writes and a
//  DEPTH-entry save/restore LIFO for call/return or interrupt entry/exit.
//  Sits beside the ALU: the ALU writes the flags, branch logic reads them, and the control
//  unit pushes/pops them. Successor to the single-bit storage cell.
// PARAMETERS
//  WIDTH      4      number of flag bits
//  DEPTH      4      save-stack entries (>=1)
//  RESET_VAL  '0     flag register value after reset
// PORTS
//  Clk        in   1                  rising-edge clock
//  Reset_n    in   1                  asynchronous, active-low reset
//  WriteEn    in   1                  masked flag write this cycle
//  WriteMask  in   WIDTH              1 = bit updated from FlagsIn
//  FlagsIn    in   WIDTH              new flag values
//  Push       in   1                  save current flags to stack
//  Pop        in   1                  restore flags from stack top
//  ErrClr     in   1                  clear sticky error (FLAG_STACK_ERR_EN only)
//  FlagsOut   out  WIDTH              current flags, combinational from register
//  Count      out  $clog2(DEPTH+1)    occupied entries
//  Full       out  1                  Count==DEPTH (combinational from Count)
//  Empty      out  1                  Count==0 (combinational from Count)
//  Overflow   out  1                  registered 1-cycle pulse: push rejected
//  Underflow  out  1                  registered 1-cycle pulse: pop rejected
//  ErrSticky  out  1                  sticky OR of Overflow|Underflow
// BEHAVIOUR
//  - Reset (async, Reset_n=0): flags=RESET_VAL, Count=0, Overflow=Underflow=ErrSticky=0.
//    Stack contents are don't-care; a reset mid-operation discards all saved entries.
//  - All state updates on posedge Clk; results are visible on FlagsOut/Count the next cycle.
//  - "cur" = flag register before the edge; "top" = entry[Count-1].
//  - Base value B: Pop accepted -> B=top, else B=cur.
//    Next flags = (B & ~WriteMask) | (FlagsIn & WriteMask) if WriteEn, else B.
//    Write therefore overrides a restored value bit-by-bit.
//  - Push only, !Full: entry[Count]=cur, Count+1.
//  - Push only, Full: rejected; stack and Count unchanged; Overflow=1 next cycle.
//  - Pop only, !Empty: Count-1.
//  - Pop only, Empty: rejected; B=cur; Underflow=1 next cycle.
//  - Push+Pop, Count>0 (including Full): swap; entry[Count-1]=cur, B=old top, Count unchanged.
//  - Push+Pop, Empty: net no-op on the stack; B=cur; no error.
//  - Pushed value is always cur, never the same-cycle write result.
//  - Overflow/Underflow are high for exactly one cycle per rejected request.
//  - Pointer arithmetic is unsigned with no wrap-around; Count saturates in [0,DEPTH] by
//    rejection, never by wrapping.
// CONFIGURATION
//  FLAG_STACK_ERR_EN defined: ErrSticky sets on any Overflow/Underflow pulse and holds until
//    an ErrClr cycle. ErrClr and a new error in the same cycle -> set wins.
//  Not defined: ErrSticky tied 0, ErrClr ignored. The port list is identical in both builds.
// STRUCTURE
//  flag_stack_pkg holds:
//    typedef enum {FS_NOP, FS_PUSH, FS_POP, FS_SWAP} fs_op_e;
//    a function decoding {Push,Pop,Empty,Full} into fs_op_e plus an accept bit.
//  Sub-module flag_stack_mem(WIDTH,DEPTH): LIFO array with write port (idx,data,en) and
//    async read of top. It has no reset on the array.
//  Top level holds the flag register, Count, error pulses and sticky bit.
// TESTING
//  1 Reset_n=0 mid-run with Count=3 -> FlagsOut=RESET_VAL, Count=0, Empty=1, pulses 0.
//  2 WIDTH=4: flags=4'b0000, WriteEn=1, Mask=4'b0101, FlagsIn=4'b1111 -> FlagsOut=4'b0101.
//  3 flags=4'hA, Push; flags written 4'h3; Pop -> FlagsOut=4'hA, Count back to 0.
//  4 DEPTH=4: 5 pushes -> Count=4, Full=1, Overflow pulses once on the 5th;
//    Pop on Empty -> Underflow pulse, flags unchanged.
//  5 Count=2, top=4'h6, flags=4'h9, Push+Pop -> FlagsOut=4'h6, Count=2, top now 4'h9;
//    Push+Pop on Empty -> no change, no error.
//  6 Pop with top=4'hF, same-cycle WriteEn Mask=4'b0001 FlagsIn=0 -> FlagsOut=4'hE;
//    with FLAG_STACK_ERR_EN: Overflow then ErrClr -> ErrSticky 1 then 0.

Source files
------------

// File: rtl/flag_stack_pkg.sv
// Shared types and the request decoder for the flag save/restore stack.
package flag_stack_pkg;

  typedef enum logic [1:0] {
    FS_NOP,
    FS_PUSH,
    FS_POP,
    FS_SWAP
  } fs_op_e;

  typedef struct packed {
    fs_op_e op;
    logic   accept;
  } fs_dec_t;

  // A simultaneous push+pop is never an error; on an empty stack it cancels out.
  function automatic fs_dec_t fsDecode(
    input logic push,
    input logic pop,
    input logic empty,
    input logic full
  );
    fs_dec_t d;
    d.op     = FS_NOP;
    d.accept = 1'b1;
    unique case (1'b1)
      push && pop: begin
        d.op = empty ? FS_NOP : FS_SWAP;
      end
      push && !pop: begin
        if (full) d.accept = 1'b0;
        else      d.op     = FS_PUSH;
      end
      !push && pop: begin
        if (empty) d.accept = 1'b0;
        else       d.op     = FS_POP;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/flag_stack_mem.sv
// LIFO storage for saved flag words: one write port, async read of the top.
module flag_stack_mem #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             Clk,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrIdx,
  input  logic [WIDTH-1:0] WrData,
  input  logic [AW-1:0]    RdIdx,
  output logic [WIDTH-1:0] RdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (WrEn) mem[WrIdx] <= WrData;
  end

  assign RdData = mem[RdIdx];

endmodule

// File: rtl/flag_stack_reg.sv
// Flag register with masked writes and a DEPTH-entry save/restore stack.
// Define FLAG_STACK_ERR_EN to enable the sticky error bit and ErrClr.
module flag_stack_reg
  import flag_stack_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(DEPTH + 1),
  localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             WriteEn,
  input  logic [WIDTH-1:0] WriteMask,
  input  logic [WIDTH-1:0] FlagsIn,
  input  logic             Push,
  input  logic             Pop,
  input  logic             ErrClr,
  output logic [WIDTH-1:0] FlagsOut,
  output logic [CW-1:0]    Count,
  output logic             Full,
  output logic             Empty,
  output logic             Overflow,
  output logic             Underflow,
  output logic             ErrSticky
);

  logic [WIDTH-1:0] flags;
  logic [WIDTH-1:0] topData;
  logic [WIDTH-1:0] baseVal;
  logic [WIDTH-1:0] nextFlags;
  logic [CW-1:0]    countM1;
  logic [AW-1:0]    topIdx;
  logic [AW-1:0]    wrIdx;
  logic             wrEn;
  logic             ovfNext;
  logic             unfNext;
  fs_dec_t          dec;

  assign Full    = (Count == CW'(DEPTH));
  assign Empty   = (Count == '0);
  assign countM1 = Count - CW'(1);
  assign topIdx  = countM1[AW-1:0];

  assign dec     = fsDecode(Push, Pop, Empty, Full);
  assign ovfNext = Push && !dec.accept;
  assign unfNext = Pop && !dec.accept;

  // The stack always saves the pre-edge flags, never this cycle's write.
  assign wrEn  = (dec.op == FS_PUSH) || (dec.op == FS_SWAP);
  assign wrIdx = (dec.op == FS_PUSH) ? Count[AW-1:0] : topIdx;

  flag_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .Clk    (Clk),
    .WrEn   (wrEn),
    .WrIdx  (wrIdx),
    .WrData (flags),
    .RdIdx  (topIdx),
    .RdData (topData)
  );

  always_comb begin
    baseVal = flags;
    if ((dec.op == FS_POP) || (dec.op == FS_SWAP)) baseVal = topData;
    nextFlags = baseVal;
    if (WriteEn) nextFlags = (baseVal & ~WriteMask) | (FlagsIn & WriteMask);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flags     <= RESET_VAL;
      Count     <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      flags     <= nextFlags;
      Overflow  <= ovfNext;
      Underflow <= unfNext;
      unique case (dec.op)
        FS_PUSH: Count <= Count + CW'(1);
        FS_POP:  Count <= countM1;
        default: ;
      endcase
    end
  end

  assign FlagsOut = flags;

`ifdef FLAG_STACK_ERR_EN
  logic errSticky;

  // A new rejection beats a simultaneous clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      errSticky <= 1'b0;
    end else if (ovfNext || unfNext) begin
      errSticky <= 1'b1;
    end else if (ErrClr) begin
      errSticky <= 1'b0;
    end
  end

  assign ErrSticky = errSticky;
`else
  logic unusedErrClr;
  assign unusedErrClr = ErrClr;
  assign ErrSticky    = 1'b0;
`endif

endmodule

// File: tb/tb_flag_stack_reg.sv
// Directed vector bench for flag_stack_reg (WIDTH=4, DEPTH=4).
// Expected sticky-error values follow FLAG_STACK_ERR_EN.
module tb_flag_stack_reg;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef FLAG_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             WriteEn;
  logic [WIDTH-1:0] WriteMask;
  logic [WIDTH-1:0] FlagsIn;
  logic             Push;
  logic             Pop;
  logic             ErrClr;
  logic [WIDTH-1:0] FlagsOut;
  logic [CW-1:0]    Count;
  logic             Full;
  logic             Empty;
  logic             Overflow;
  logic             Underflow;
  logic             ErrSticky;

  int nChecks = 0;
  int nFails  = 0;

  flag_stack_reg #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (4'h0)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .WriteEn   (WriteEn),
    .WriteMask (WriteMask),
    .FlagsIn   (FlagsIn),
    .Push      (Push),
    .Pop       (Pop),
    .ErrClr    (ErrClr),
    .FlagsOut  (FlagsOut),
    .Count     (Count),
    .Full      (Full),
    .Empty     (Empty),
    .Overflow  (Overflow),
    .Underflow (Underflow),
    .ErrSticky (ErrSticky)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       we;
    logic [3:0] mask;
    logic [3:0] fin;
    logic       push;
    logic       pop;
    logic [3:0] eFlags;
    int         eCnt;
    logic       eOvf;
    logic       eUnf;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] mask,
                       input logic [3:0] fin, input logic push,
                       input logic pop, input logic clr);
    @(negedge Clk);
    WriteEn   = we;
    WriteMask = mask;
    FlagsIn   = fin;
    Push      = push;
    Pop       = pop;
    ErrClr    = clr;
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input logic we, input logic [3:0] mask,
                     input logic [3:0] fin, input logic push,
                     input logic pop, input logic [3:0] ef,
                     input int ec, input logic eo, input logic eu);
    vq.push_back('{we, mask, fin, push, pop, ef, ec, eo, eu});
  endtask

  logic expSticky;

  initial begin
    Reset_n   = 1'b0;
    WriteEn   = 1'b0;
    WriteMask = '0;
    FlagsIn   = '0;
    Push      = 1'b0;
    Pop       = 1'b0;
    ErrClr    = 1'b0;
    expSticky = 1'b0;

    //  we mask fin push pop | flags cnt ovf unf
    add(1, 4'h5, 4'hF, 0, 0,  4'h5, 0, 0, 0);
    add(1, 4'hF, 4'hA, 0, 0,  4'hA, 0, 0, 0);
    add(0, 4'h0, 4'h0, 1, 0,  4'hA, 1, 0, 0);
    add(1, 4'hF, 4'h3, 0, 0,  4'h3, 1, 0, 0);
    add(0, 4'h0, 4'h0, 0, 1,  4'hA, 0, 0, 0);
    add(0, 4'h0, 4'h0, 0, 1,  4'hA, 0, 0, 1);
    add(0, 4'h0, 4'h0, 0, 0,  4'hA, 0, 0, 0);
    add(0, 4'h0, 4'h0, 1, 1,  4'hA, 0, 0, 0);
    add(1, 4'hF, 4'hF, 0, 0,  4'hF, 0, 0, 0);
    add(0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 0);
    add(1, 4'hF, 4'h6, 0, 0,  4'h6, 1, 0, 0);
    add(0, 4'h0, 4'h0, 1, 0,  4'h6, 2, 0, 0);
    add(1, 4'hF, 4'h9, 0, 0,  4'h9, 2, 0, 0);
    add(0, 4'h0, 4'h0, 1, 1,  4'h6, 2, 0, 0);
    add(0, 4'h0, 4'h0, 0, 1,  4'h9, 1, 0, 0);
    add(1, 4'h1, 4'h0, 0, 1,  4'hE, 0, 0, 0);
    add(0, 4'h0, 4'h0, 1, 0,  4'hE, 1, 0, 0);
    add(0, 4'h0, 4'h0, 1, 0,  4'hE, 2, 0, 0);
    add(0, 4'h0, 4'h0, 1, 0,  4'hE, 3, 0, 0);
    add(0, 4'h0, 4'h0, 1, 0,  4'hE, 4, 0, 0);
    add(0, 4'h0, 4'h0, 1, 0,  4'hE, 4, 1, 0);
    add(0, 4'h0, 4'h0, 0, 0,  4'hE, 4, 0, 0);
    add(1, 4'hF, 4'h5, 0, 0,  4'h5, 4, 0, 0);
    add(0, 4'h0, 4'h0, 1, 1,  4'hE, 4, 0, 0);
    add(0, 4'h0, 4'h0, 0, 1,  4'h5, 3, 0, 0);
    add(1, 4'hF, 4'h7, 1, 0,  4'h7, 4, 0, 0);
    add(0, 4'h0, 4'h0, 0, 1,  4'h5, 3, 0, 0);

    #12;
    chk("rst_flags", int'(FlagsOut), 0);
    chk("rst_count", int'(Count), 0);
    chk("rst_empty", int'(Empty), 1);
    chk("rst_full", int'(Full), 0);
    chk("rst_ovf", int'(Overflow), 0);
    chk("rst_unf", int'(Underflow), 0);
    chk("rst_sticky", int'(ErrSticky), 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].we, vq[i].mask, vq[i].fin, vq[i].push, vq[i].pop, 1'b0);
      expSticky = ERR_EN && (expSticky || vq[i].eOvf || vq[i].eUnf);
      chk($sformatf("v%0d_flags", i), int'(FlagsOut), int'(vq[i].eFlags));
      chk($sformatf("v%0d_count", i), int'(Count), vq[i].eCnt);
      chk($sformatf("v%0d_full", i), int'(Full), int'(vq[i].eCnt == DEPTH));
      chk($sformatf("v%0d_empty", i), int'(Empty), int'(vq[i].eCnt == 0));
      chk($sformatf("v%0d_ovf", i), int'(Overflow), int'(vq[i].eOvf));
      chk($sformatf("v%0d_unf", i), int'(Underflow), int'(vq[i].eUnf));
      chk($sformatf("v%0d_sticky", i), int'(ErrSticky), int'(expSticky));
    end

    // Asynchronous reset with three saved entries, between clock edges.
    drive(0, 4'h0, 4'h0, 0, 1, 1'b0);
    chk("pre_rst_unf_src_count", int'(Count), 2);
    drive(0, 4'h0, 4'h0, 1, 0, 1'b0);
    @(negedge Clk);
    Push = 1'b0;
    Pop  = 1'b1;
    #2;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_flags", int'(FlagsOut), 0);
    chk("mid_rst_count", int'(Count), 0);
    chk("mid_rst_empty", int'(Empty), 1);
    chk("mid_rst_ovf", int'(Overflow), 0);
    chk("mid_rst_unf", int'(Underflow), 0);
    chk("mid_rst_sticky", int'(ErrSticky), 0);
    @(negedge Clk);
    Pop     = 1'b0;
    Reset_n = 1'b1;

    // Saved entries are gone: a pop right after reset is rejected.
    drive(0, 4'h0, 4'h0, 0, 1, 1'b0);
    chk("post_rst_unf", int'(Underflow), 1);
    chk("post_rst_count", int'(Count), 0);

    // Overflow pulse, sticky hold, clear, and set-beats-clear.
    for (int k = 0; k < 4; k++) drive(0, 4'h0, 4'h0, 1, 0, 1'b0);
    chk("fill_count", int'(Count), 4);
    drive(0, 4'h0, 4'h0, 1, 0, 1'b0);
    chk("ovf_pulse", int'(Overflow), 1);
    chk("ovf_sticky", int'(ErrSticky), int'(ERR_EN));
    drive(0, 4'h0, 4'h0, 0, 0, 1'b0);
    chk("ovf_drop", int'(Overflow), 0);
    chk("sticky_hold", int'(ErrSticky), int'(ERR_EN));
    drive(0, 4'h0, 4'h0, 0, 0, 1'b1);
    chk("sticky_clr", int'(ErrSticky), 0);
    drive(0, 4'h0, 4'h0, 1, 0, 1'b1);
    chk("clr_vs_set_ovf", int'(Overflow), 1);
    chk("clr_vs_set_sticky", int'(ErrSticky), int'(ERR_EN));
    chk("full_held", int'(Count), 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
